// File: rtl/tag_bs_encoder.sv
// Tag-side FM0 backscatter transmitter.
// Sends a fixed preamble, then bit_len FM0 data bits taken MSB-first from
// bytes fetched over a byte handshake, then an end-of-signalling dummy 1.
// The mod output is registered and holds every half-symbol for HALF clocks.
module tag_bs_encoder #(
  parameter int                   PRE_LEN = 12,
  parameter logic [PRE_LEN-1:0]   PRE_PAT = 12'b110100100011,
  parameter int                   HALF0   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] bit_len,
  input  logic       dr_sel0,
  input  logic       dr_sel1,
  input  logic [7:0] dbus_in,
  output logic       ack,
  output logic       mod,
  output logic       busy,
  output logic       done
);

  // The counter must reach the longest half-symbol (HALF0 << 3) minus one.
  localparam int CNT_W = $clog2(HALF0 * 8);
  // Half-symbol index: up to 2*256 data halves within the DATA state.
  localparam int IDX_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    EOS  = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;        // clock within the current half-symbol
  logic [IDX_W-1:0]   idx;        // half-symbol index within the current state
  logic [1:0]         dr_q;       // data rate latched with start
  logic [8:0]         len_q;      // saturated bit_len latched with start
  logic [PRE_LEN-1:0] pre_sr;     // remaining preamble levels, next one in the MSB
  logic [7:0]         shreg;      // data byte, bit being sent in the MSB

  logic [8:0]         len_sat;
  logic [CNT_W-1:0]   half_last;
  logic [IDX_W-1:0]   last_data;

  // Saturate the requested length, derive the half-symbol length and the
  // index of the final data half from the latched frame parameters.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    len_sat   = (bit_len > 9'd256) ? 9'd256 : bit_len;
    half_last = CNT_W'((HALF0 << dr_q) - 1);
    last_data = {len_q, 1'b0} - 10'd1;
  end

  // Frame sequencer: steps half-symbols and produces the registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      dr_q   <= '0;
      len_q  <= '0;
      pre_sr <= '0;
      shreg  <= '0;
      ack    <= 1'b0;
      mod    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      ack  <= 1'b0;
      done <= 1'b0;
      if (state == IDLE) begin
        // A start coinciding with the done pulse is deliberately ignored.
        if (start && !done) begin
          state  <= PRE;
          len_q  <= len_sat;
          dr_q   <= {dr_sel1, dr_sel0};
          cnt    <= '0;
          idx    <= '0;
          mod    <= PRE_PAT[PRE_LEN-1];
          pre_sr <= PRE_PAT << 1;
          busy   <= 1'b1;
        end
      end else if (cnt != half_last) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        case (state)
          PRE: begin
            if (idx == IDX_W'(PRE_LEN - 1)) begin
              idx <= '0;
              mod <= ~mod;                  // FM0 symbol boundary inversion
              if (len_q != 9'd0) begin
                state <= DATA;
                shreg <= dbus_in;           // byte for data bits 0..7
                ack   <= 1'b1;
              end else begin
                state <= EOS;
              end
            end else begin
              idx    <= idx + 1'b1;
              mod    <= pre_sr[PRE_LEN-1];
              pre_sr <= pre_sr << 1;
            end
          end
          DATA: begin
            if (!idx[0]) begin
              // Second half: a 1 keeps the level, a 0 toggles mid-symbol.
              idx <= idx + 1'b1;
              mod <= shreg[7] ? mod : ~mod;
            end else if (idx == last_data) begin
              state <= EOS;
              idx   <= '0;
              mod   <= ~mod;
            end else begin
              idx <= idx + 1'b1;
              mod <= ~mod;
              // Next bit is a multiple of 8: take a fresh byte from the bus.
              if (idx[3:0] == 4'hF) begin
                shreg <= dbus_in;
                ack   <= 1'b1;
              end else begin
                shreg <= shreg << 1;
              end
            end
          end
          EOS: begin
            if (!idx[0]) begin
              idx <= idx + 1'b1;            // dummy 1: level held
            end else begin
              state <= IDLE;
              idx   <= '0;
              mod   <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tag_bs_encoder.sv
// Self-checking bench for tag_bs_encoder. A reference model builds the
// expected half-symbol level list of each frame from the FM0 rules, then
// every clock of the frame is compared against it.
module tb_tag_bs_encoder;

  localparam logic [11:0] PRE_PAT = 12'b110100100011;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [8:0] bit_len;
  logic       dr_sel0;
  logic       dr_sel1;
  logic [7:0] dbus_in;
  logic       ack;
  logic       mod;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] bytes [0:31];
  int         halves[$];

  always #5 clk = ~clk;

  tag_bs_encoder dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bit_len (bit_len),
    .dr_sel0 (dr_sel0),
    .dr_sel1 (dr_sel1),
    .dbus_in (dbus_in),
    .ack     (ack),
    .mod     (mod),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) bytes[i] = 8'($urandom);
  endtask

  // Runs one frame and checks mod/busy/ack/done on every clock.
  // abort_at >= 0 asserts reset at that frame clock; disturb pokes the
  // frame inputs mid-frame and pulses start on the done cycle.
  task automatic run_frame(input int n, input int dr, input int abort_at, input bit disturb);
    int         nsat, h, total, bidx, prev, f, s, ack_base;
    logic [11:0] pp;
    logic [7:0]  cur;
    bit          exp_ack;
    pp   = PRE_PAT;
    nsat = (n > 256) ? 256 : n;
    h    = 8 << dr;
    halves.delete();
    for (int i = 0; i < 12; i++) halves.push_back(int'(pp[11-i]));
    prev = halves[11];
    for (int b = 0; b < nsat; b++) begin
      cur  = bytes[b / 8];
      f    = 1 - prev;
      s    = cur[7 - (b % 8)] ? f : 1 - f;
      halves.push_back(f);
      halves.push_back(s);
      prev = s;
    end
    f = 1 - prev;
    halves.push_back(f);
    halves.push_back(f);
    total    = halves.size() * h;
    ack_base = 12 * h;

    @(negedge clk);
    start   = 1'b1;
    bit_len = 9'(n);
    dr_sel0 = dr[0];
    dr_sel1 = dr[1];
    dbus_in = bytes[0];
    bidx    = 0;
    @(negedge clk);
    start = 1'b0;

    for (int c = 0; c < total; c++) begin
      if (abort_at >= 0 && c == abort_at) begin
        reset = 1'b0;
        #1;
        check("abort_mod", mod, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        check("abort_done", done, 0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_idle_busy", busy, 0);
        check("abort_idle_done", done, 0);
        return;
      end
      exp_ack = (c >= ack_base) && ((c - ack_base) % (16 * h) == 0) &&
                ((c - ack_base) / (2 * h) < nsat);
      check("mod", mod, halves[c / h]);
      check("busy", busy, 1);
      check("done_early", done, 0);
      check("ack", ack, exp_ack);
      if (ack && bidx < 31) begin
        bidx++;
        dbus_in = bytes[bidx];
      end
      if (disturb && c == total / 2) begin
        start   = 1'b1;
        bit_len = 9'd3;
        dr_sel0 = ~dr_sel0;
        dr_sel1 = ~dr_sel1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end

    check("done", done, 1);
    check("end_busy", busy, 0);
    check("end_mod", mod, 0);
    check("end_ack", ack, 0);
    start = disturb;
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", done, 0);
    check("no_restart", busy, 0);
    @(negedge clk);
    check("still_idle", busy, 0);
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    bit_len = '0;
    dr_sel0 = 1'b0;
    dr_sel1 = 1'b0;
    dbus_in = '0;
    repeat (3) @(negedge clk);
    check("rst_mod", mod, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_done", done, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single byte A5 at the fastest rate.
    fill_random();
    bytes[0] = 8'hA5;
    run_frame(8, 0, -1, 1'b0);

    // Empty frame: preamble then EOS.
    run_frame(0, 0, -1, 1'b0);

    // Partial final byte.
    bytes[0] = 8'h3C;
    bytes[1] = 8'hF0;
    bytes[2] = 8'h9A;
    run_frame(20, 1, -1, 1'b0);

    // Slowest rate, single 1 bit.
    bytes[0] = 8'h80;
    run_frame(1, 3, -1, 1'b0);

    // Mid-frame input changes and restarts are ignored.
    fill_random();
    run_frame(24, 0, -1, 1'b1);

    // Reset during DATA, then a clean frame.
    fill_random();
    run_frame(40, 2, (12 + 10) * 32, 1'b0);
    run_frame(16, 0, -1, 1'b0);

    // Random frames.
    for (int k = 0; k < 5; k++) begin
      fill_random();
      run_frame(int'($urandom_range(1, 24)), int'($urandom_range(0, 3)), -1, 1'b0);
    end

    // Oversized length saturates to 256.
    fill_random();
    run_frame(300, 0, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
